arb_mux4x1_4bits: RTL and testbench



---
 rtl/arb_mux4x1_4bits_if.sv | 23 ++
 rtl/arb_mux4x1_4bits.sv | 161 ++++++++++++++++
 tb/tb_arb_mux4x1_4bits.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_mux4x1_4bits_if.sv
// Shared-bus interface of the 4-requester arbiter/mux: request lines, requester
// nibbles and the registered grant/select/data/valid results.
interface arb_mux4x1_4bits_if;
    logic [3:0] REQ;
    logic [3:0] ENT0;
    logic [3:0] ENT1;
    logic [3:0] ENT2;
    logic [3:0] ENT3;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic [3:0] saida;
    logic       VALID;

    modport master (
        output REQ, ENT0, ENT1, ENT2, ENT3,
        input  GNT, SEL, saida, VALID
    );

    modport slave (
        input  REQ, ENT0, ENT1, ENT2, ENT3,
        output GNT, SEL, saida, VALID
    );
endinterface

// File: rtl/arb_mux4x1_4bits.sv
// Round-robin arbiter sharing a 4-bit 4:1 mux between four requesters, bursts
// bounded by MAX_BEATS. Define ARB_FIXED_PRIO_EN for fixed priority (0 highest).
module arb_mux4x1_4bits #(
    parameter int unsigned MAX_BEATS = 32'd8
) (
    input  logic               CLK,
    input  logic               RST,
    arb_mux4x1_4bits_if.slave  bus
);
    localparam int p_SEL = 2;
    localparam int p_ent = 4;
    localparam logic [7:0] LIMIT = 8'(MAX_BEATS - 32'd1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [7:0]       cnt_r, cnt_s;
    logic [3:0]       gnt_r, gnt_s;
    logic [p_SEL-1:0] sel_r, sel_s;
    logic [p_ent-1:0] saida_r, saida_s;
    logic             valid_r, valid_s;
    logic [p_ent-1:0] mux_s;
    logic [1:0]       base_s;
    logic [2:0]       pick_s;
    logic             beat_s;
`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]       last_r, last_s;
`endif

    // Search base+1, base+2, base+3, base (mod 4); returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Data path mux selected by the registered winner index.
    always_comb begin
        mux_s = 4'h0;
        case (sel_r)
            2'd0:    mux_s = bus.ENT0;
            2'd1:    mux_s = bus.ENT1;
            2'd2:    mux_s = bus.ENT2;
            2'd3:    mux_s = bus.ENT3;
            default: mux_s = 4'h0;
        endcase
    end

    // Arbitration: base 3 means plain 0..3 order; otherwise start after LAST or the current winner.
    always_comb begin
        base_s = 2'd3;
`ifndef ARB_FIXED_PRIO_EN
        if (state_r == BUSY) begin
            base_s = sel_r;
        end else begin
            base_s = last_r;
        end
`endif
        pick_s = rr_pick(bus.REQ, base_s);
    end

    // Next-state, grant, beat and release decisions.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        saida_s = saida_r;
        valid_s = 1'b0;
        beat_s  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        last_s  = last_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    state_s = BUSY;
                    gnt_s   = 4'b0001 << pick_s[1:0];
                    sel_s   = pick_s[1:0];
                    cnt_s   = 8'd0;
                end else begin
                    gnt_s   = 4'b0000;
                end
            end
            BUSY: begin
                beat_s = bus.REQ[sel_r];
                if (beat_s) begin
                    valid_s = 1'b1;
                    saida_s = mux_s;
                end else begin
                    valid_s = 1'b0;
                end
                // A dropped request or an exhausted budget hands the bus on without a bubble.
                if (!beat_s || (cnt_r == LIMIT)) begin
`ifndef ARB_FIXED_PRIO_EN
                    last_s = sel_r;
`endif
                    if (pick_s[2]) begin
                        state_s = BUSY;
                        gnt_s   = 4'b0001 << pick_s[1:0];
                        sel_s   = pick_s[1:0];
                        cnt_s   = 8'd0;
                    end else begin
                        state_s = IDLE;
                        gnt_s   = 4'b0000;
                        cnt_s   = 8'd0;
                    end
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 4'b0000;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            saida_r <= 4'h0;
            valid_r <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_r  <= 2'd3;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            saida_r <= saida_s;
            valid_r <= valid_s;
`ifndef ARB_FIXED_PRIO_EN
            last_r  <= last_s;
`endif
        end
    end

    assign bus.GNT   = gnt_r;
    assign bus.SEL   = sel_r;
    assign bus.saida = saida_r;
    assign bus.VALID = valid_r;
endmodule

// File: tb/tb_arb_mux4x1_4bits.sv
// Bench for arb_mux4x1_4bits: four instances (MAX_BEATS 1,2,3,8) on shared stimulus,
// each checked every cycle against a behavioural model, plus literal expectations.
module tb_arb_mux4x1_4bits;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ent [4];

    int checks   = 0;
    int failures = 0;

    logic [3:0] gnt_o   [4];
    logic [1:0] sel_o   [4];
    logic [3:0] saida_o [4];
    logic       valid_o [4];

    always #5 clk = ~clk;

    function automatic int mb_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        arb_mux4x1_4bits_if bus ();
        assign bus.REQ  = req;
        assign bus.ENT0 = ent[0];
        assign bus.ENT1 = ent[1];
        assign bus.ENT2 = ent[2];
        assign bus.ENT3 = ent[3];
        arb_mux4x1_4bits #(.MAX_BEATS(mb_of(g))) dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus)
        );
        assign gnt_o[g]   = bus.GNT;
        assign sel_o[g]   = bus.SEL;
        assign saida_o[g] = bus.saida;
        assign valid_o[g] = bus.VALID;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_known = 1'b0;
    bit         m_busy  [4];
    int         m_cur   [4];
    int         m_cnt   [4];
    int         m_last  [4];
    logic [3:0] e_gnt   [4];
    logic [1:0] e_sel   [4];
    logic [3:0] e_saida [4];
    logic       e_valid [4];

    // First requester found scanning after+1, after+2, ... (mod 4); -1 if none.
    function automatic int pick(input logic [3:0] r, input int after);
        for (int j = 1; j <= 4; j++) begin
            if (r[(after + j) % 4]) return (after + j) % 4;
        end
        return -1;
    endfunction

    function automatic int base_for(input int last_or_cur);
`ifdef ARB_FIXED_PRIO_EN
        return 3;
`else
        return last_or_cur;
`endif
    endfunction

    task automatic grant_to(input int k, input int w);
        m_busy[k] = 1'b1;
        m_cur[k]  = w;
        m_cnt[k]  = 0;
        e_gnt[k]  = 4'(1 << w);
        e_sel[k]  = 2'(w);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("gnt[%0d]", k), {4'h0, gnt_o[k]}, {4'h0, e_gnt[k]});
                    chk($sformatf("sel[%0d]", k), {6'h0, sel_o[k]}, {6'h0, e_sel[k]});
                    chk($sformatf("saida[%0d]", k), {4'h0, saida_o[k]}, {4'h0, e_saida[k]});
                    chk($sformatf("valid[%0d]", k), {7'h0, valid_o[k]}, {7'h0, e_valid[k]});
                    if (gnt_o[k] != 4'b0000) begin
                        chk($sformatf("gnt_sel_match[%0d]", k),
                            {7'h0, gnt_o[k] == 4'(1 << sel_o[k])}, 8'h01);
                    end
                end
            end
            // Outcome of the coming rising edge, from the inputs it will sample.
            for (int k = 0; k < 4; k++) begin
                int w;
                if (rst) begin
                    m_busy[k] = 1'b0; m_cnt[k] = 0; m_last[k] = 3; m_cur[k] = 0;
                    e_gnt[k] = 4'h0; e_sel[k] = 2'd0; e_saida[k] = 4'h0; e_valid[k] = 1'b0;
                end else if (!m_busy[k]) begin
                    e_valid[k] = 1'b0;
                    w = pick(req, base_for(m_last[k]));
                    if (w >= 0) grant_to(k, w);
                    else e_gnt[k] = 4'h0;
                end else begin
                    bit beat;
                    beat = req[m_cur[k]];
                    e_valid[k] = beat;
                    if (beat) e_saida[k] = ent[m_cur[k]];
                    if (!beat || m_cnt[k] == mb_of(k) - 1) begin
                        m_last[k] = m_cur[k];
                        w = pick(req, base_for(m_cur[k]));
                        if (w >= 0) grant_to(k, w);
                        else begin
                            m_busy[k] = 1'b0;
                            e_gnt[k]  = 4'h0;
                        end
                    end else begin
                        m_cnt[k]++;
                    end
                end
            end
            if (rst) m_known = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'h0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    localparam logic [3:0] ROT_GNT_RR [9] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
    localparam logic [3:0] ROT_SAI_RR [9] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3};
    localparam logic [3:0] DIR_REQ [6] = '{4'b0011, 4'b1000, 4'b0000, 4'b0110, 4'b1001, 4'b0101};
    localparam int         DIR_LEN [6] = '{5, 2, 2, 7, 4, 6};

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) ent[i] = 4'(i + 5);

        // Reset held two cycles with all requests up.
        for (int c = 0; c < 2; c++) begin
            cyc(1);
            for (int k = 0; k < 4; k++) begin
                chk("rst_gnt", {4'h0, gnt_o[k]}, 8'h00);
                chk("rst_sel", {6'h0, sel_o[k]}, 8'h00);
                chk("rst_saida", {4'h0, saida_o[k]}, 8'h00);
                chk("rst_valid", {7'h0, valid_o[k]}, 8'h00);
            end
        end
        rst = 1'b0;
        cyc(1);
        for (int k = 0; k < 4; k++) chk("first_gnt", {4'h0, gnt_o[k]}, 8'h01);

        // Single burst from requester 2 on the MAX_BEATS=8 instance.
        do_reset();
        ent[2] = 4'hA;
        req    = 4'b0100;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk("burst_gnt", {4'h0, gnt_o[3]}, 8'h04);
            chk("burst_valid", {7'h0, valid_o[3]}, (i > 1) ? 8'h01 : 8'h00);
            if (i > 1) chk("burst_saida", {4'h0, saida_o[3]}, 8'h0A);
        end
        req = 4'b0000;
        cyc(1);
        chk("burst_end_gnt", {4'h0, gnt_o[3]}, 8'h00);
        chk("burst_end_valid", {7'h0, valid_o[3]}, 8'h00);
        chk("burst_end_saida", {4'h0, saida_o[3]}, 8'h0A);
        cyc(2);

        // Beat limit and rotation on the MAX_BEATS=2 instance.
        do_reset();
        for (int i = 0; i < 4; i++) ent[i] = 4'(i);
        req = 4'b1111;
        for (int e = 0; e < 9; e++) begin
            cyc(1);
`ifdef ARB_FIXED_PRIO_EN
            chk("rot_gnt", {4'h0, gnt_o[1]}, 8'h01);
            chk("rot_saida", {4'h0, saida_o[1]}, 8'h00);
`else
            chk("rot_gnt", {4'h0, gnt_o[1]}, {4'h0, ROT_GNT_RR[e]});
            chk("rot_saida", {4'h0, saida_o[1]}, {4'h0, ROT_SAI_RR[e]});
`endif
            chk("rot_valid", {7'h0, valid_o[1]}, (e > 0) ? 8'h01 : 8'h00);
        end

        // Sole requester re-granted without gaps on the MAX_BEATS=3 instance.
        do_reset();
        req = 4'b0001;
        cyc(1);
        for (int e = 0; e < 10; e++) begin
            cyc(1);
            chk("sole_gnt", {4'h0, gnt_o[2]}, 8'h01);
            chk("sole_valid", {7'h0, valid_o[2]}, 8'h01);
        end

        // Reset in the middle of a burst on the MAX_BEATS=8 instance.
        do_reset();
        req = 4'b0010;
        cyc(1);
        chk("mid_gnt", {4'h0, gnt_o[3]}, 8'h02);
        cyc(2);
        chk("mid_valid", {7'h0, valid_o[3]}, 8'h01);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_gnt", {4'h0, gnt_o[3]}, 8'h00);
        chk("mid_rst_valid", {7'h0, valid_o[3]}, 8'h00);
        rst = 1'b0;
        cyc(1);
        chk("mid_regnt", {4'h0, gnt_o[3]}, 8'h02);
        chk("mid_regnt_valid", {7'h0, valid_o[3]}, 8'h00);
        cyc(1);
        chk("mid_regnt_beat", {7'h0, valid_o[3]}, 8'h01);

        // Two competing requesters with one beat per grant.
        do_reset();
        ent[1] = 4'h5;
        ent[3] = 4'hC;
        req    = 4'b1010;
        for (int e = 0; e < 6; e++) begin
            cyc(1);
`ifdef ARB_FIXED_PRIO_EN
            chk("alt_gnt", {4'h0, gnt_o[0]}, 8'h02);
`else
            chk("alt_gnt", {4'h0, gnt_o[0]}, (e % 2 == 0) ? 8'h02 : 8'h08);
`endif
        end

        // Directed request pattern sequence with changing data, model-checked.
        do_reset();
        for (int p = 0; p < 6; p++) begin
            req = DIR_REQ[p];
            for (int c = 0; c < DIR_LEN[p]; c++) begin
                for (int i = 0; i < 4; i++) ent[i] = 4'((p * 7 + c * 3 + i * 5) & 15);
                cyc(1);
            end
        end
        req = 4'h0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
